beam_timing_gen: RTL and testbench
==================================

// Module: beam_timing_gen
// PURPOSE
// Parametrised, programmable video beam timing generator; next generation of the fixed agnus_beamcounter
// timing. Runs H/V beam counters on a clock enable and produces sync, blank, eol/eof strobes and
// long_frame for interlace. Timing comes from CPU-written registers, double-buffered and applied at
// frame end. Feeds amber (scandoubler) and RTG line compare.
// PARAMETERS
// HW        9    horizontal counter width (bits)
// VW        11   vertical counter width (bits)
// AW        4    register address width (word index)
// DEF_HTOT  227  reset HTOTAL (last hpos of a line, PAL CCK)
// DEF_VTOT  312  reset VTOTAL (last vpos of a long frame, PAL)
// PORTS
// clk          in   1   bus clock (28 MHz)
// reset        in   1   asynchronous, active-high reset
// clk_en       in   1   beam advance enable (one pulse per CCK)
// wr           in   1   register write strobe, sampled on clk
// reg_addr     in   AW  register index
// data_in      in   16  write data
// data_out     out  16  readback of addressed register (live copy), registered
// hpos         out  HW  horizontal beam position
// vpos         out  VW  vertical beam position
// _hsync       out  1   horizontal sync, polarity per CTRL[1]
// _vsync       out  1   vertical sync, polarity per CTRL[2]
// blank        out  1   hblank | vblank
// eol          out  1   1-clk pulse, last position of line
// eof          out  1   1-clk pulse, last position of frame
// long_frame   out  1   current frame is long (odd) field
// htotal_out   out  HW  active (shadow) HTOTAL
// BEHAVIOUR
// - Reset: hpos=0, vpos=0, long_frame=1, _hsync=1, _vsync=1, blank=1, eol=0, eof=0, data_out=0;
//   live+shadow regs = defaults (HTOT=DEF_HTOT, VTOT=DEF_VTOT, others 0, CTRL=0). Reset mid-frame aborts.
// - Reg map: 0 HTOTAL,1 HSSTRT,2 HSSTOP,3 HBSTRT,4 HBSTOP,5 VTOTAL,6 VSSTRT,7 VSSTOP,8 VBSTRT,9 VBSTOP,
//   10 CTRL (b0 interlace, b1 hsync active-high, b2 vsync active-high, b3 LOF write value).
//   Writes truncate to HW/VW LSBs. Addr >10: writes ignored, reads 0. data_out valid 1 clk after addr.
// - Writes go to live regs; shadow <= live on the clk_en cycle that ends the frame (eof). CTRL b3 write
//   sets long_frame immediately. Power-up/first frame uses defaults.
// - Counting only when clk_en=1. hpos==HTOTAL: hpos->0, vpos++; else hpos++. Frame end when
//   vpos==VTOTAL (long) or vpos==VTOTAL-1 (short, interlace only), at hpos==HTOTAL: vpos->0.
// - At frame end: long_frame <= ~long_frame if interlace else 1. Never produce short frame w/o interlace.
// - eol/eof asserted the clk after the clk_en cycle where hpos==HTOTAL (resp. frame end); exactly 1 clk.
// - hsync active for HSSTRT<=hpos<HSSTOP; hblank for HBSTRT<=hpos<HBSTOP; if STOP<STRT the window wraps
//   (active when hpos>=STRT or hpos<STOP). STRT==STOP: never active. Same rules for vsync/vblank on vpos.
// - Interlace short frame: vsync edges occur at hpos==HTOTAL>>1 instead of hpos==0 (half-line offset).
// - All outputs registered: sync/blank reflect hpos/vpos with 1 clk latency vs counter update.
// - Polarity bits apply combinationally to registered active flag; change takes effect next clk.
// - If HTOTAL/VTOTAL written below current position, counter continues to wrap at 2^HW/2^VW only after
//   shadow load; shadow compare is equality so overshoot runs to counter wrap then restarts at 0.
// TESTING
// - Reset, clk_en every 4 clk, defaults -> eol every 228 CCK, eof every 313 lines, long_frame stays 1.
// - Write HTOTAL=99 mid-frame -> line length unchanged until after next eof, then eol every 100 CCK.
// - CTRL=1 (interlace), VTOT=312 -> alternating 313/312-line frames, long_frame toggles at each eof.
// - HSSTRT=200,HSSTOP=10 (wrap) -> _hsync low for hpos 200..227 and 0..9, high elsewhere; CTRL b1=1 inverts.
// - Short interlace frame, VSSTRT=2 -> _vsync falls at vpos=2, hpos=HTOTAL>>1; long frame at hpos=0.
// - Assert reset mid-line at hpos=57 -> all outputs at reset values same clk; restart from hpos=0,vpos=0.

Source files
------------

// File: rtl/beam_timing_gen.sv
// beam_timing_gen: programmable H/V beam timing generator; timing registers are double-buffered
// and the shadow copy is loaded at frame end.
module beam_timing_gen #(
  parameter int HW       = 9,
  parameter int VW       = 11,
  parameter int AW       = 4,
  parameter int DEF_HTOT = 227,
  parameter int DEF_VTOT = 312
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          wr,
  input  logic [AW-1:0] reg_addr,
  input  logic [15:0]   data_in,
  output logic [15:0]   data_out,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          _hsync,
  output logic          _vsync,
  output logic          blank,
  output logic          eol,
  output logic          eof,
  output logic          long_frame,
  output logic [HW-1:0] htotal_out
);
  typedef struct packed {
    logic [HW-1:0] htot, hss, hse, hbs, hbe;
    logic [VW-1:0] vtot, vss, vse, vbs, vbe;
  } timing_t;
  localparam timing_t DEF = '{HW'(DEF_HTOT), '0, '0, '0, '0, VW'(DEF_VTOT), '0, '0, '0, '0};
  timing_t       live, shd;
  logic [3:0]    ctrl;
  logic          ilace, hs, vs, h_end, f_end, short_f;
  logic [VW-1:0] v_eff;
  logic [15:0]   rd;
  function automatic logic win_h(input logic [HW-1:0] p, s, e);
    return s < e ? (p >= s && p < e) : (s > e && (p >= s || p < e));
  endfunction
  function automatic logic win_v(input logic [VW-1:0] p, s, e);
    return s < e ? (p >= s && p < e) : (s > e && (p >= s || p < e));
  endfunction
  assign short_f = ilace & ~long_frame;
  assign h_end   = hpos == shd.htot;
  assign f_end   = h_end && (vpos == shd.vtot || (short_f && vpos == shd.vtot - VW'(1)));
  // short interlace field: vertical sync tracks a line that starts half-way across
  assign v_eff      = (short_f && hpos < (shd.htot >> 1)) ? vpos - VW'(1) : vpos;
  assign _hsync     = ctrl[1] ? hs : ~hs;
  assign _vsync     = ctrl[2] ? vs : ~vs;
  assign htotal_out = shd.htot;
  always_comb begin
    rd = '0;
    case (32'(reg_addr))
      0:       rd = 16'(live.htot);
      1:       rd = 16'(live.hss);
      2:       rd = 16'(live.hse);
      3:       rd = 16'(live.hbs);
      4:       rd = 16'(live.hbe);
      5:       rd = 16'(live.vtot);
      6:       rd = 16'(live.vss);
      7:       rd = 16'(live.vse);
      8:       rd = 16'(live.vbs);
      9:       rd = 16'(live.vbe);
      10:      rd = 16'(ctrl);
      default: rd = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live       <= DEF;
      shd        <= DEF;
      ctrl       <= '0;
      ilace      <= 1'b0;
      hpos       <= '0;
      vpos       <= '0;
      long_frame <= 1'b1;
      hs         <= 1'b0;
      vs         <= 1'b0;
      blank      <= 1'b1;
      eol        <= 1'b0;
      eof        <= 1'b0;
      data_out   <= '0;
    end else begin
      data_out <= rd;
      hs       <= win_h(hpos, shd.hss, shd.hse);
      vs       <= win_v(v_eff, shd.vss, shd.vse);
      blank    <= win_h(hpos, shd.hbs, shd.hbe) | win_v(vpos, shd.vbs, shd.vbe);
      eol      <= clk_en & h_end;
      eof      <= clk_en & f_end;
      if (clk_en) begin
        hpos <= h_end ? '0 : hpos + HW'(1);
        vpos <= f_end ? '0 : h_end ? vpos + VW'(1) : vpos;
        if (f_end) begin
          shd        <= live;
          ilace      <= ctrl[0];
          long_frame <= ilace ? ~long_frame : 1'b1;
        end
      end
      if (wr)
        case (32'(reg_addr))
          0:       live.htot <= HW'(data_in);
          1:       live.hss  <= HW'(data_in);
          2:       live.hse  <= HW'(data_in);
          3:       live.hbs  <= HW'(data_in);
          4:       live.hbe  <= HW'(data_in);
          5:       live.vtot <= VW'(data_in);
          6:       live.vss  <= VW'(data_in);
          7:       live.vse  <= VW'(data_in);
          8:       live.vbs  <= VW'(data_in);
          9:       live.vbe  <= VW'(data_in);
          10: begin
            ctrl       <= 4'(data_in);
            long_frame <= data_in[3];
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_beam_timing_gen.sv
// tb_beam_timing_gen: register table, directed timing sequences and random traffic against a
// frame-level reference model; a second default-parameter instance checks the reset timing.
module tb_beam_timing_gen;
  localparam int HM = 'h1FF;
  localparam int VM = 'h7FF;
  logic clk = 0, reset = 1, clk_en = 0, wr = 0;
  logic [3:0] reg_addr = 0;
  logic [15:0] data_in = 0, data_out;
  logic [8:0] hpos, htotal_out;
  logic [10:0] vpos;
  logic hsync_n, vsync_n, blank, eol, eof, long_frame;
  logic d_wr = 0;
  logic [3:0] d_addr = 0;
  logic [15:0] d_din = 0, d_dout;
  logic [8:0] d_hpos, d_htot;
  logic [10:0] d_vpos;
  logic d_hs, d_vs, d_blank, d_eol, d_eof, d_lf;
  beam_timing_gen #(.DEF_HTOT(19), .DEF_VTOT(9)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .wr(wr), .reg_addr(reg_addr), .data_in(data_in),
    .data_out(data_out), .hpos(hpos), .vpos(vpos), ._hsync(hsync_n), ._vsync(vsync_n), .blank(blank),
    .eol(eol), .eof(eof), .long_frame(long_frame), .htotal_out(htotal_out));
  beam_timing_gen u_def (
    .clk(clk), .reset(reset), .clk_en(clk_en), .wr(d_wr), .reg_addr(d_addr), .data_in(d_din),
    .data_out(d_dout), .hpos(d_hpos), .vpos(d_vpos), ._hsync(d_hs), ._vsync(d_vs), .blank(d_blank),
    .eol(d_eol), .eof(d_eof), .long_frame(d_lf), .htotal_out(d_htot));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int m_h, m_v, m_lf, e_dout;
  int live[11], shd[11];
  bit e_hs, e_vs, e_blank, e_eol, e_eof;
  int ph, pv;
  bit pvs;
  typedef struct {int a; int d; int e;} vec_t;
  vec_t tbl[18];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic fail_to(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", nm, $time);
  endtask
  function automatic bit win(input int p, input int s, input int e);
    if (s < e) return p >= s && p < e;
    if (s > e) return p >= s || p < e;
    return 0;
  endfunction
  task automatic model_reset();
    foreach (live[i]) live[i] = 0;
    live[0] = 19;
    live[5] = 9;
    shd = live;
    m_h = 0; m_v = 0; m_lf = 1; e_dout = 0;
    e_hs = 0; e_vs = 0; e_blank = 1; e_eol = 0; e_eof = 0;
  endtask
  // one clock of the programmable beam: outputs from the position before the edge
  task automatic model_step(input bit en, input bit w, input int a, input int d);
    bit he, fe, sf;
    int ve;
    e_dout = a <= 10 ? live[a] : 0;
    sf = shd[10][0] && m_lf == 0;
    ve = (sf && m_h < shd[0] / 2) ? (m_v - 1) & VM : m_v;
    e_hs = win(m_h, shd[1], shd[2]);
    e_vs = win(ve, shd[6], shd[7]);
    e_blank = win(m_h, shd[3], shd[4]) || win(m_v, shd[8], shd[9]);
    he = m_h == shd[0];
    fe = he && (m_v == shd[5] || (sf && m_v == ((shd[5] - 1) & VM)));
    e_eol = en && he;
    e_eof = en && fe;
    if (en) begin
      m_h = he ? 0 : (m_h + 1) & HM;
      m_v = fe ? 0 : he ? (m_v + 1) & VM : m_v;
      if (fe) begin
        m_lf = shd[10][0] ? 1 - m_lf : 1;
        shd = live;
      end
    end
    if (w && a <= 10) begin
      live[a] = d & (a < 5 ? HM : a < 10 ? VM : 15);
      if (a == 10) m_lf = (d >> 3) & 1;
    end
  endtask
  task automatic compare_all();
    chk("hpos", hpos, m_h);
    chk("vpos", vpos, m_v);
    chk("long_frame", long_frame, m_lf);
    chk("hsync_n", hsync_n, live[10][1] ? int'(e_hs) : int'(!e_hs));
    chk("vsync_n", vsync_n, live[10][2] ? int'(e_vs) : int'(!e_vs));
    chk("blank", blank, e_blank);
    chk("eol", eol, e_eol);
    chk("eof", eof, e_eof);
    chk("data_out", data_out, e_dout);
    chk("htotal_out", htotal_out, shd[0]);
  endtask
  task automatic tick(input bit en, input bit w, input int a, input int d);
    ph = hpos; pv = vpos; pvs = vsync_n;
    clk_en = en; wr = w; reg_addr = 4'(a); data_in = 16'(d);
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step(en, w, a, d);
    compare_all();
  endtask
  task automatic wait_eof();
    for (int i = 0; i < 1000; i++) begin
      tick(1, 0, 0, 0);
      if (eof) return;
    end
    fail_to("wait_eof");
  endtask
  task automatic eol_period(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1, 0, 0, 0);
      if (seen) n++;
      if (eol) begin
        if (seen) return;
        seen = 1;
      end
    end
    fail_to("eol_period");
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    int cnt, n, lines, fh, fv, lows;
    bit seen, done, en, got, d_eof_seen;
    tbl = '{'{0, 'hFFFF, 'h1FF}, '{5, 'hFFFF, 'h7FF}, '{3, 'h1234, 'h034}, '{8, 'hABCD, 'h3CD},
            '{10, 'hFFFF, 'hF}, '{11, 'h1234, 0}, '{15, 'hFFFF, 0}, '{0, 19, 19}, '{1, 2, 2},
            '{2, 5, 5}, '{3, 16, 16}, '{4, 1, 1}, '{5, 9, 9}, '{6, 1, 1}, '{7, 2, 2}, '{8, 8, 8},
            '{9, 1, 1}, '{10, 8, 8}};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("def_hsync_rst", d_hs, 1);
    chk("def_vsync_rst", d_vs, 1);
    chk("def_blank_rst", d_blank, 1);
    chk("def_htot_rst", d_htot, 227);
    reset = 0;
    d_addr = 0;
    tick(0, 0, 0, 0);
    chk("def_rd_htot", d_dout, 227);
    d_addr = 5;
    tick(0, 0, 0, 0);
    chk("def_rd_vtot", d_dout, 312);
    // default timing: a line is 228 CCKs with clk_en every fourth clock
    cnt = 0; seen = 0; done = 0; d_eof_seen = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      en = i % 4 == 0;
      tick(en, 0, 0, 0);
      if (en) cnt++;
      if (d_eof) d_eof_seen = 1;
      if (d_eol) begin
        if (seen) begin
          chk("def_eol_period", cnt, 228);
          done = 1;
        end
        seen = 1;
        cnt = 0;
      end
    end
    if (!done) fail_to("def_eol");
    chk("def_long_frame", d_lf, 1);
    chk("def_no_eof", d_eof_seen, 0);
    foreach (tbl[i]) begin
      tick(0, 1, tbl[i].a, tbl[i].d);
      tick(0, 0, tbl[i].a, 0);
      chk("rd_tbl", data_out, tbl[i].e);
    end
    // HTOTAL write applies only after the next frame end
    wait_eof();
    repeat (30) tick(1, 0, 0, 0);
    tick(1, 1, 0, 11);
    eol_period(n);
    chk("eol_before_load", n, 20);
    wait_eof();
    eol_period(n);
    chk("eol_after_load", n, 12);
    tick(1, 1, 0, 19);
    tick(1, 1, 1, 15);
    tick(1, 1, 2, 3);
    tick(1, 1, 6, 2);
    tick(1, 1, 7, 4);
    tick(1, 1, 10, 1);
    wait_eof();
    chk("lf_after_load", long_frame, 1);
    for (int f = 0; f < 3; f++) begin
      lines = 0; fh = -1; fv = -1; got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
        tick(1, 0, 0, 0);
        if (eol) lines++;
        if (pvs && !vsync_n) begin
          fh = ph;
          fv = pv;
        end
        if (eof) got = 1;
      end
      if (!got) fail_to("frame_end");
      chk("frame_lines", lines, f == 1 ? 9 : 10);
      chk("vs_fall_v", fv, 2);
      chk("vs_fall_h", fh, f == 1 ? 9 : 0);
      chk("lf_toggle", long_frame, f == 1 ? 1 : 0);
    end
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0);
      if (!hsync_n) lows++;
    end
    chk("hsync_low_cnt", lows, 8);
    tick(1, 1, 10, 3);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0, 0);
      if (hsync_n) lows++;
    end
    chk("hsync_high_cnt", lows, 8);
    for (int i = 0; i < 5000; i++) begin
      int a, d;
      a = $urandom_range(0, 12);
      d = a == 0 ? $urandom_range(6, 24) : a == 5 ? $urandom_range(3, 10) :
          a < 5 ? $urandom_range(0, 25) : a < 10 ? $urandom_range(0, 11) :
          a == 10 ? $urandom_range(0, 15) : $urandom_range(0, 'hFFFF);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a, d);
    end
    // asynchronous reset in the middle of a default-timing line
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick(1, 0, 0, 0);
      done = d_hpos == 57;
    end
    if (!done) fail_to("reach_hpos57");
    #2 reset = 1;
    #1;
    model_reset();
    compare_all();
    chk("rst_def_hpos", d_hpos, 0);
    chk("rst_def_vpos", d_vpos, 0);
    chk("rst_def_lf", d_lf, 1);
    chk("rst_def_eol", d_eol, 0);
    chk("rst_def_hsync", d_hs, 1);
    chk("rst_def_blank", d_blank, 1);
    repeat (2) tick(1, 0, 0, 0);
    reset = 0;
    tick(1, 0, 0, 0);
    chk("restart_def_hpos", d_hpos, 1);
    chk("restart_def_vpos", d_vpos, 0);
    repeat (40) tick(1, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
